// File: rtl/addsub_pkg.sv
// Shared definitions for the chunked sequential adder/subtractor:
// the controller state encoding and the default datapath geometry.
package addsub_pkg;

  // Default operand/result width and the number of bits handled per RUN cycle.
  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 8;

  // Controller states: waiting for a request, stepping through chunks,
  // presenting the result until the consumer takes it.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/addsub_seq_if.sv
// Request/response bundle for addsub_seq. The master side issues operands
// and accepts results; the slave side is the arithmetic block itself.
interface addsub_seq_if import addsub_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
);

  // Request channel
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             sub;
  logic             sat;

  // Response channel
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             overflow;
  logic             zero;
  logic             neg;

  modport master (
    output in_valid, x, y, sub, sat, out_ready,
    input  in_ready, out_valid, s, cout, overflow, zero, neg
  );

  modport slave (
    input  in_valid, x, y, sub, sat, out_ready,
    output in_ready, out_valid, s, cout, overflow, zero, neg
  );

endinterface

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit ripple adder. Besides the carry out of the top
// bit it exposes the carry into the top bit, which the parent XORs with
// cout to detect signed overflow on the most significant chunk.
module addsub_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  // Ripple the carry bit by bit, tapping it just before the top position.
  always_comb begin
    logic c;
    // NOTE: every output is assigned a default before the loop, so no path
    // leaves a value unassigned and no latch is inferred.
    sum      = '0;
    c_msb_in = 1'b0;
    c        = cin;
    for (int i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) begin
        c_msb_in = c;
      end
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/addsub_seq.sv
// Sequential two's-complement adder/subtractor. A request is captured in
// IDLE, the sum is built CHUNK bits per cycle in RUN through one shared
// chunk adder, and the final result plus flags are held in DONE until the
// consumer accepts them. WIDTH must be a multiple of CHUNK.
module addsub_seq import addsub_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic         clk,
  input  logic         rst,
  addsub_seq_if.slave  bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;      // already inverted for subtraction
  logic             sat_q;
  logic [WIDTH-1:0] work;     // partial sum, separate from the visible result

  // Visible result registers; they keep the previous answer during RUN.
  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;
  logic             neg_q;

  // Chunk adder hookup and end-of-operation result assembly.
  int               base;
  logic [CHUNK-1:0] c_sum;
  logic             c_cout;
  logic             c_msb_in;
  logic             ovf_now;
  logic [WIDTH-1:0] full_sum;
  logic [WIDTH-1:0] sat_val;
  logic [WIDTH-1:0] final_s;

  addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a        (x_q[base +: CHUNK]),
    .b        (y_q[base +: CHUNK]),
    .cin      (carry),
    .sum      (c_sum),
    .cout     (c_cout),
    .c_msb_in (c_msb_in)
  );

  // Merge the chunk being added this cycle into the partial sum and apply
  // saturation; only consumed on the last RUN cycle.
  always_comb begin
    base                     = 32'(idx) * CHUNK;
    full_sum                 = work;
    full_sum[base +: CHUNK]  = c_sum;
    ovf_now                  = c_cout ^ c_msb_in;
    // Clamp toward the sign of x: positive overflow only happens for x >= 0.
    sat_val  = x_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                            : {1'b0, {(WIDTH-1){1'b1}}};
    final_s  = (sat_q && ovf_now) ? sat_val : full_sum;
  end

  // Controller and datapath state; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      sat_q  <= 1'b0;
      work   <= '0;
      s_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            x_q   <= bus.x;
            y_q   <= bus.sub ? ~bus.y : bus.y;
            sat_q <= bus.sat;
            carry <= bus.sub;   // +1 completes the two's-complement negate
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          work[base +: CHUNK] <= c_sum;
          carry               <= c_cout;
          if (idx == LAST_IDX) begin
            idx    <= '0;
            s_q    <= final_s;
            cout_q <= c_cout;
            ovf_q  <= ovf_now;
            zero_q <= (final_s == '0);
            neg_q  <= final_s[WIDTH-1];
            state  <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.s         = s_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Bench for addsub_seq (WIDTH=32, CHUNK=8): directed vectors with literal
// expectations, then randomized traffic compared every cycle against a
// transaction-level model built from plain signed/unsigned arithmetic.
module tb_addsub_seq;
  import addsub_pkg::*;

  localparam int NCHUNK = 4;

  typedef struct packed {
    logic [31:0] s;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        neg;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   cmp_en   = 1'b0;

  addsub_seq_if #(.WIDTH(32)) bus ();

  addsub_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result from the arithmetic definition of add/subtract.
  function automatic res_t ref_op(input logic [31:0] a, input logic [31:0] b,
                                  input bit sb, input bit st);
    res_t        r;
    logic [63:0] full;
    longint      ideal;
    full  = {32'b0, a} + {32'b0, (sb ? ~b : b)} + 64'(sb);
    ideal = sb ? (longint'($signed(a)) - longint'($signed(b)))
               : (longint'($signed(a)) + longint'($signed(b)));
    r.cout = full[32];
    r.ovf  = (ideal > 64'sd2147483647) || (ideal < -64'sd2147483648);
    r.s    = full[31:0];
    if (st && r.ovf) r.s = (ideal > 0) ? 32'h7fffffff : 32'h80000000;
    r.zero = (r.s == 32'd0);
    r.neg  = r.s[31];
    return r;
  endfunction

  // Transaction-level model: busy from accept until the result is taken,
  // result becomes visible NCHUNK edges after accept.
  bit   m_busy  = 1'b0;
  int   m_age   = 0;
  res_t m_next  = '0;
  res_t m_shown = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy  <= 1'b0;
      m_age   <= 0;
      m_shown <= '0;
    end else if (!m_busy) begin
      if (bus.in_valid) begin
        m_busy <= 1'b1;
        m_age  <= 0;
        m_next <= ref_op(bus.x, bus.y, bus.sub, bus.sat);
      end
    end else if (m_age == NCHUNK) begin
      if (bus.out_ready) m_busy <= 1'b0;
    end else begin
      m_age <= m_age + 1;
      if (m_age == NCHUNK - 1) m_shown <= m_next;
    end
  end

  // Every-cycle comparison, sampled on the falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_in_ready",  32'(bus.in_ready),  32'(!m_busy));
      check("cmp_out_valid", 32'(bus.out_valid), 32'(m_busy && (m_age == NCHUNK)));
      check("cmp_s",         bus.s,              m_shown.s);
      check("cmp_cout",      32'(bus.cout),      32'(m_shown.cout));
      check("cmp_overflow",  32'(bus.overflow),  32'(m_shown.ovf));
      check("cmp_zero",      32'(bus.zero),      32'(m_shown.zero));
      check("cmp_neg",       32'(bus.neg),       32'(m_shown.neg));
    end
  end

  // Present one request at a falling edge and hold it across the accept edge.
  task automatic start_op(input logic [31:0] xv, input logic [31:0] yv,
                          input bit sb, input bit st);
    int k = 0;
    while (!bus.in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!bus.in_ready) check("start_timeout", 32'(bus.in_ready), 32'd1);
    bus.x = xv; bus.y = yv; bus.sub = sb; bus.sat = st;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.x = $urandom; bus.y = $urandom;
  endtask

  // Count edges after the accept edge until out_valid is seen; 0 on timeout.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0:       return 32'h0;
      1:       return 32'h7fffffff;
      2:       return 32'h80000000;
      3:       return 32'hffffffff;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int   lat;
    res_t r;
    bus.in_valid = 1'b0; bus.x = '0; bus.y = '0; bus.sub = 1'b0; bus.sat = 1'b0;
    bus.out_ready = 1'b0;

    // Pin the reference model to hand-computed values.
    r = ref_op(32'd11, 32'd2999999, 1'b0, 1'b0);
    check("model_add_s", r.s, 32'd3000010);
    r = ref_op(32'h7fffffff, 32'd1, 1'b0, 1'b1);
    check("model_sat_pos", r.s, 32'h7fffffff);
    check("model_sat_ovf", 32'(r.ovf), 32'd1);
    r = ref_op(32'd0, 32'd0, 1'b1, 1'b0);
    check("model_sub0_cout", 32'(r.cout), 32'd1);
    r = ref_op(-32'sd323, -32'sd77771, 1'b1, 1'b0);
    check("model_sub_neg", r.s, 32'd77448);

    // Reset state.
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_s",         bus.s,              32'd0);
    check("rst_flags", {28'd0, bus.cout, bus.overflow, bus.zero, bus.neg}, 32'd0);
    #2 rst = 1'b0;
    @(negedge clk);
    cmp_en = 1'b1;

    // Plain add with latency measurement.
    start_op(32'd11, 32'd2999999, 1'b0, 1'b0);
    wait_done(lat);
    check("add_latency", 32'(lat), 32'd4);
    check("add_s", bus.s, 32'd3000010);
    check("add_cout_ovf", {30'd0, bus.cout, bus.overflow}, 32'd0);
    release_result();

    // Positive overflow, wrapped then saturated.
    start_op(32'h7fffffff, 32'd1, 1'b0, 1'b0);
    wait_done(lat);
    check("ovf_wrap_s", bus.s, 32'h80000000);
    check("ovf_wrap_flags", {30'd0, bus.overflow, bus.neg}, 32'd3);
    release_result();
    start_op(32'h7fffffff, 32'd1, 1'b0, 1'b1);
    wait_done(lat);
    check("ovf_sat_s", bus.s, 32'h7fffffff);
    check("ovf_sat_ovf", 32'(bus.overflow), 32'd1);
    release_result();

    // Subtraction corners.
    start_op(32'd0, 32'd0, 1'b1, 1'b0);
    wait_done(lat);
    check("sub0_s", bus.s, 32'd0);
    check("sub0_cout_zero", {30'd0, bus.cout, bus.zero}, 32'd3);
    release_result();
    start_op(32'h80000000, 32'd1, 1'b1, 1'b1);
    wait_done(lat);
    check("sub_sat_s", bus.s, 32'h80000000);
    check("sub_sat_ovf", 32'(bus.overflow), 32'd1);
    release_result();

    // Back-pressure: result must hold while out_ready is low.
    start_op(-32'sd323, -32'sd77771, 1'b1, 1'b0);
    wait_done(lat);
    for (int h = 0; h < 5; h++) begin
      check("hold_s", bus.s, 32'd77448);
      check("hold_ovf", 32'(bus.overflow), 32'd0);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
    end
    release_result();

    // Reset while the third chunk is pending.
    start_op(32'd1234, 32'd5678, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("abort_no_valid", 32'(bus.out_valid), 32'd0);
    end
    check("abort_s", bus.s, 32'd0);
    check("abort_flags", {28'd0, bus.cout, bus.overflow, bus.zero, bus.neg}, 32'd0);
    start_op(32'd10, 32'd20, 1'b0, 1'b0);
    wait_done(lat);
    check("after_abort_s", bus.s, 32'd30);
    release_result();

    // Randomized traffic, including requests while busy and rare resets.
    for (int c = 0; c < 4000; c++) begin
      bus.in_valid  = ($urandom % 2) == 0;
      bus.x         = pick();
      bus.y         = pick();
      bus.sub       = $urandom % 2;
      bus.sat       = $urandom % 2;
      bus.out_ready = ($urandom % 4) != 0;
      if ($urandom % 300 == 0) begin
        #2 rst = 1'b1;
        #2 rst = 1'b0;
      end
      @(negedge clk);
    end

    bus.in_valid = 1'b0;
    @(negedge clk);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/addsub_seq.md
ADDSUB_SEQ -- requirements
Module: addsub_seq

Interface
REQ-001 WIDTH, 32, operand/result width in bits; SHALL be a multiple of CHUNK.
REQ-002 CHUNK, 8, bits processed per RUN cycle; NCHUNK = WIDTH/CHUNK SHALL be >= 1.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  operand request valid.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 x  input  WIDTH  first operand, two's complement.
REQ-008 y  input  WIDTH  second operand, two's complement.
REQ-009 sub  input  1  0 = x+y, 1 = x-y.
REQ-010 sat  input  1  1 = saturate result on signed overflow.
REQ-011 out_valid  output  1  result and flags valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 s  output  WIDTH  result.
REQ-014 cout  output  1  carry out of MSB, never saturated.
REQ-015 overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB.
REQ-016 zero  output  1  s == 0, computed after saturation.
REQ-017 neg  output  1  s[WIDTH-1], computed after saturation.

Function
REQ-018 States SHALL be IDLE, RUN, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-019 Accept SHALL occur on an edge with in_valid && in_ready; x, y, sub, sat captured there; inputs ignored in all other cycles.
REQ-020 On accept: IDLE->RUN, chunk index = 0, carry register = sub.
REQ-021 Each RUN cycle SHALL add chunk idx of x and (sub ? ~y : y) chunk idx plus carry register, store CHUNK sum bits into result bits [idx*CHUNK +: CHUNK], update carry register, increment idx.
REQ-022 When idx == NCHUNK-1: RUN->DONE; cout, overflow, zero, neg and final s registered on that edge.
REQ-023 Latency: out_valid SHALL rise exactly NCHUNK cycles after the accepting edge (4 for defaults).
REQ-024 If sat=1 and overflow=1: s SHALL be 0 followed by WIDTH-1 ones when x[MSB]=0, else 1 followed by WIDTH-1 zeros; overflow flag still reports 1.
REQ-025 In DONE, s and all flags SHALL hold stable while out_ready=0.
REQ-026 DONE with out_ready=1 -> IDLE on that edge; in_ready high the following cycle (no same-cycle reaccept).
REQ-027 s and flags SHALL retain last result in IDLE/RUN until overwritten at next RUN->DONE.
REQ-028 NCHUNK=1 SHALL complete in a single RUN cycle.
REQ-029 Arithmetic modulo 2^WIDTH; no other exceptions.

Reset
REQ-030 rst=1 SHALL immediately force IDLE, idx=0, carry=0, s=0, cout=0, overflow=0, zero=0, neg=0, out_valid=0, in_ready=1 after release.
REQ-031 Reset mid-RUN or mid-DONE SHALL abandon the operation with no output produced.

Structure
REQ-032 Shared package addsub_pkg SHALL hold the state enum and default WIDTH/CHUNK constants.
REQ-033 Sub-module addsub_chunk (combinational CHUNK-bit ripple adder: a, b, cin -> sum, cout, c_msb_in) SHALL be instantiated once; c_msb_in feeds overflow on the last chunk.

Verification (WIDTH=32, CHUNK=8)
REQ-034 sub=0 x=11 y=2999999 -> s=3000010, cout=0, overflow=0, out_valid exactly 4 cycles after accept.
REQ-035 sub=0 sat=0 x=0x7FFFFFFF y=1 -> s=0x80000000, overflow=1, neg=1; same with sat=1 -> s=0x7FFFFFFF, overflow=1.
REQ-036 sub=1 x=0 y=0 -> s=0, cout=1, zero=1; sub=1 sat=1 x=0x80000000 y=1 -> s=0x80000000, overflow=1.
REQ-037 sub=1 x=-323 y=-77771 -> s=77448, overflow=0; out_ready held 0 for 5 cycles -> s/flags stable, in_ready=0 throughout.
REQ-038 rst pulsed during RUN idx=2 -> out_valid never rises, all outputs 0, next request x=10 y=20 sub=0 -> s=30.
